// File: rtl/goose_game_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | goose_game_ctrl_pkg                                                  |
// | Shared game-state encodings and visible-area defaults.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package goose_game_ctrl_pkg;

  typedef logic [1:0]  state_t;
  typedef logic [15:0] cnt16_t;

  localparam state_t c_IDLE  = 2'd0;
  localparam state_t c_START = 2'd1;
  localparam state_t c_RUN   = 2'd2;
  localparam state_t c_HIT   = 2'd3;

  localparam int c_H_VIS_DEF = 640;
  localparam int c_V_VIS_DEF = 480;

  function automatic cnt16_t max16(input cnt16_t a, input cnt16_t b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/goose_game_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | goose_game_ctrl_if                                                   |
// | Pixel/button inputs and game-state outputs of the game controller.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface goose_game_ctrl_if;
  import goose_game_ctrl_pkg::*;

  logic [9:0]  x;
  logic [9:0]  y;
  logic        goose;
  logic        bean;
  logic [1:0]  button;
  logic        stop;
  logic        game_reset;
  logic [31:0] score;
  logic [31:0] hi_score;
  state_t      state;

  // master drives pixels/buttons, slave is the controller
  modport master (
    output x, y, goose, bean, button,
    input  stop, game_reset, score, hi_score, state
  );

  modport slave (
    input  x, y, goose, bean, button,
    output stop, game_reset, score, hi_score, state
  );

endinterface
`default_nettype wire

// File: rtl/goose_game_ctrl_frame_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_tick_gen                                                       |
// | One-cycle registered pulse for the cycle after pixel (0,0).          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_tick_gen (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       tick
);

  logic r_tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick <= 1'b0;
    end else begin
      r_tick <= (x == 10'd0) && (y == 10'd0);
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/goose_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | goose_game_ctrl                                                      |
// | IDLE/START/RUN/HIT game FSM with collision detect and scoring.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module goose_game_ctrl
  import goose_game_ctrl_pkg::*;
#(
  parameter int SCORE_DIV    = 6,
  parameter int SCORE_MAX    = 9999,
  parameter int START_FRAMES = 2,
  parameter int HIT_FRAMES   = 30,
  parameter int H_VIS        = c_H_VIS_DEF,
  parameter int V_VIS        = c_V_VIS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  goose_game_ctrl_if.slave   bus
);

  localparam cnt16_t      c_DIV_LAST   = cnt16_t'(SCORE_DIV - 1);
  localparam cnt16_t      c_SCORE_MAX  = cnt16_t'(SCORE_MAX);
  localparam cnt16_t      c_START_LAST = cnt16_t'(START_FRAMES - 1);
  localparam cnt16_t      c_HIT_MIN    = cnt16_t'(HIT_FRAMES);
  localparam logic [10:0] c_H_VIS      = 11'(H_VIS);
  localparam logic [10:0] c_V_VIS      = 11'(V_VIS);

  logic [1:0] r_rst_sync;
  logic       w_rst_n;
  logic       w_tick;
  logic       w_collide;
  logic       r_btn_prev;
  logic       r_press;
  state_t     r_state;
  state_t     w_state_nxt;
  cnt16_t     r_frame_cnt;
  cnt16_t     w_frame_nxt;
  cnt16_t     r_div_cnt;
  cnt16_t     w_div_nxt;
  cnt16_t     r_score;
  cnt16_t     w_score_nxt;
  cnt16_t     r_hi_score;
  cnt16_t     w_hi_nxt;
  logic       r_stop;
  logic       r_game_reset;

  // Assert asynchronously, release two clocks after reset goes high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  frame_tick_gen u_frame_tick_gen (
    .clk   (clk),
    .reset (w_rst_n),
    .x     (bus.x),
    .y     (bus.y),
    .tick  (w_tick)
  );

  assign w_collide = bus.goose & bus.bean
                   & ({1'b0, bus.x} < c_H_VIS)
                   & ({1'b0, bus.y} < c_V_VIS);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_btn_prev <= 1'b0;
      r_press    <= 1'b0;
    end else begin
      r_btn_prev <= |bus.button;
      r_press    <= (|bus.button) & ~r_btn_prev;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame_cnt;
    w_div_nxt   = r_div_cnt;
    w_score_nxt = r_score;
    w_hi_nxt    = r_hi_score;
    case (r_state)
      c_IDLE: begin
        if (r_press) begin
          w_state_nxt = c_START;
          w_frame_nxt = '0;
          w_div_nxt   = '0;
          w_score_nxt = '0;
        end
      end
      c_START: begin
        if (w_tick) begin
          if (r_frame_cnt >= c_START_LAST) begin
            w_state_nxt = c_RUN;
            w_frame_nxt = '0;
            w_div_nxt   = '0;
          end else begin
            w_frame_nxt = r_frame_cnt + 16'd1;
          end
        end
      end
      c_RUN: begin
        // Collision has priority over a coincident frame tick
        if (w_collide) begin
          w_state_nxt = c_HIT;
          w_frame_nxt = '0;
          w_div_nxt   = '0;
          w_hi_nxt    = max16(r_hi_score, r_score);
        end else if (w_tick) begin
          if (r_div_cnt >= c_DIV_LAST) begin
            w_div_nxt = '0;
            if (r_score < c_SCORE_MAX) begin
              w_score_nxt = r_score + 16'd1;
            end
          end else begin
            w_div_nxt = r_div_cnt + 16'd1;
          end
        end
      end
      c_HIT: begin
        if (r_press && (r_frame_cnt >= c_HIT_MIN)) begin
          w_state_nxt = c_START;
          w_frame_nxt = '0;
          w_div_nxt   = '0;
          w_score_nxt = '0;
        end else if (w_tick && (r_frame_cnt != 16'hFFFF)) begin
          w_frame_nxt = r_frame_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= c_IDLE;
      r_frame_cnt  <= '0;
      r_div_cnt    <= '0;
      r_score      <= '0;
      r_hi_score   <= '0;
      r_stop       <= 1'b1;
      r_game_reset <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_cnt  <= w_frame_nxt;
      r_div_cnt    <= w_div_nxt;
      r_score      <= w_score_nxt;
      r_hi_score   <= w_hi_nxt;
      r_stop       <= (w_state_nxt != c_RUN);
      r_game_reset <= (w_state_nxt == c_IDLE) || (w_state_nxt == c_START);
    end
  end

  assign bus.state      = r_state;
  assign bus.stop       = r_stop;
  assign bus.game_reset = r_game_reset;
  assign bus.score      = {16'd0, r_score};
  assign bus.hi_score   = {16'd0, r_hi_score};

endmodule
`default_nettype wire

// File: tb/tb_goose_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_goose_game_ctrl                                                   |
// | Scoreboard bench: default controller plus a SCORE_MAX=12 instance.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_goose_game_ctrl;

  typedef struct {
    string       tag;
    bit          dut;
    logic [1:0]  st;
    logic        stp;
    logic        grst;
    logic [31:0] score;
    logic [31:0] hi;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_goose;
  logic       r_bean;
  logic [1:0] r_button;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t m_e;

  goose_game_ctrl_if bus  ();
  goose_game_ctrl_if bus2 ();

  assign bus.x       = r_x;
  assign bus.y       = r_y;
  assign bus.goose   = r_goose;
  assign bus.bean    = r_bean;
  assign bus.button  = r_button;
  assign bus2.x      = r_x;
  assign bus2.y      = r_y;
  assign bus2.goose  = r_goose;
  assign bus2.bean   = r_bean;
  assign bus2.button = r_button;

  goose_game_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  goose_game_ctrl #(.SCORE_MAX(12)) u_dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input bit dut, input logic [1:0] st,
                            input logic stp, input logic grst, input int sc, input int hi);
    exp_t e;
    e.tag   = tag;
    e.dut   = dut;
    e.st    = st;
    e.stp   = stp;
    e.grst  = grst;
    e.score = 32'(sc);
    e.hi    = 32'(hi);
    exp_q.push_back(e);
  endtask

  // Pending expectations describe the outputs after the most recent edge
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      if (m_e.dut) begin
        check_val({m_e.tag, ".state"}, 32'(bus2.state),      32'(m_e.st));
        check_val({m_e.tag, ".stop"},  32'(bus2.stop),       32'(m_e.stp));
        check_val({m_e.tag, ".grst"},  32'(bus2.game_reset), 32'(m_e.grst));
        check_val({m_e.tag, ".score"}, bus2.score,           m_e.score);
        check_val({m_e.tag, ".hi"},    bus2.hi_score,        m_e.hi);
      end else begin
        check_val({m_e.tag, ".state"}, 32'(bus.state),       32'(m_e.st));
        check_val({m_e.tag, ".stop"},  32'(bus.stop),        32'(m_e.stp));
        check_val({m_e.tag, ".grst"},  32'(bus.game_reset),  32'(m_e.grst));
        check_val({m_e.tag, ".score"}, bus.score,            m_e.score);
        check_val({m_e.tag, ".hi"},    bus.hi_score,         m_e.hi);
      end
    end
  end

  task automatic step(input logic [9:0] px, input logic [9:0] py,
                      input logic g, input logic b, input logic [1:0] btn);
    r_x      = px;
    r_y      = py;
    r_goose  = g;
    r_bean   = b;
    r_button = btn;
    @(posedge clk);
    #1;
  endtask

  task automatic park();
    step(10'd700, 10'd500, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(10'd0, 10'd0, 1'b0, 1'b0, 2'b00);
      park();
    end
  endtask

  task automatic press(input logic [1:0] btn);
    step(10'd700, 10'd500, 1'b0, 1'b0, btn);
    park();
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    r_x      = 10'd700;
    r_y      = 10'd500;
    r_goose  = 1'b0;
    r_bean   = 1'b0;
    r_button = 2'b00;
    repeat (3) park();
    expect_out("in_reset", 1'b0, 2'd0, 1'b1, 1'b1, 0, 0);
    park();
    reset = 1'b1;
    repeat (8) park();
    expect_out("idle", 1'b0, 2'd0, 1'b1, 1'b1, 0, 0);
    park();

    // First game
    press(2'b01);
    expect_out("press", 1'b0, 2'd1, 1'b1, 1'b1, 0, 0);
    frames(1);
    expect_out("start_f1", 1'b0, 2'd1, 1'b1, 1'b1, 0, 0);
    frames(1);
    expect_out("run", 1'b0, 2'd2, 1'b0, 1'b0, 0, 0);
    frames(60);
    expect_out("run60", 1'b0, 2'd2, 1'b0, 1'b0, 10, 0);
    frames(60);
    expect_out("run120", 1'b0, 2'd2, 1'b0, 1'b0, 20, 0);
    expect_out("sat120", 1'b1, 2'd2, 1'b0, 1'b0, 12, 0);
    frames(12);
    expect_out("sat_hold", 1'b1, 2'd2, 1'b0, 1'b0, 12, 0);
    step(10'd700, 10'd200, 1'b1, 1'b1, 2'b00);
    expect_out("off_x700", 1'b0, 2'd2, 1'b0, 1'b0, 22, 0);
    step(10'd640, 10'd200, 1'b1, 1'b1, 2'b00);
    expect_out("off_x640", 1'b0, 2'd2, 1'b0, 1'b0, 22, 0);
    step(10'd320, 10'd480, 1'b1, 1'b1, 2'b00);
    expect_out("off_y480", 1'b0, 2'd2, 1'b0, 1'b0, 22, 0);
    step(10'd320, 10'd200, 1'b1, 1'b1, 2'b00);
    expect_out("hit", 1'b0, 2'd3, 1'b1, 1'b0, 22, 22);
    expect_out("hit_sat", 1'b1, 2'd3, 1'b1, 1'b0, 12, 12);
    park();

    // HIT lockout, then restart
    frames(10);
    press(2'b10);
    expect_out("hit_early", 1'b0, 2'd3, 1'b1, 1'b0, 22, 22);
    frames(21);
    press(2'b01);
    expect_out("restart", 1'b0, 2'd1, 1'b1, 1'b1, 0, 22);
    expect_out("restart_sat", 1'b1, 2'd1, 1'b1, 1'b1, 0, 12);

    // Second, lower-scoring game
    frames(2);
    frames(12);
    step(10'd639, 10'd479, 1'b1, 1'b1, 2'b00);
    expect_out("hit2", 1'b0, 2'd3, 1'b1, 1'b0, 2, 22);
    expect_out("hit2_sat", 1'b1, 2'd3, 1'b1, 1'b0, 2, 12);
    park();

    // Third game: collision coinciding with the wrapping tick
    frames(30);
    press(2'b11);
    frames(2);
    frames(11);
    expect_out("div5", 1'b0, 2'd2, 1'b0, 1'b0, 1, 22);
    step(10'd0, 10'd0, 1'b0, 1'b0, 2'b00);
    step(10'd320, 10'd200, 1'b1, 1'b1, 2'b00);
    expect_out("tick_hit", 1'b0, 2'd3, 1'b1, 1'b0, 1, 22);
    park();

    // Fourth game, reset mid-run
    frames(30);
    press(2'b01);
    frames(5);
    expect_out("run3", 1'b0, 2'd2, 1'b0, 1'b0, 0, 22);
    drain();
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_state", 32'(bus.state), 32'd0);
    check_val("async_stop", 32'(bus.stop), 32'd1);
    check_val("async_hi", bus.hi_score, 32'd0);
    repeat (2) park();
    reset = 1'b1;
    repeat (8) park();
    expect_out("post_rst", 1'b0, 2'd0, 1'b1, 1'b1, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
